ue14500_host: RTL and testbench
===============================

# ue14500_host

Host-side controller for the UE14500 1-bit CPU core: owns program memory, program counter, return stack and a 16-bit I/O data space. It drives the core's instruction nibble, data-in bit and synchronous reset, and consumes its flag, write and data-out lines. The core and this block share one clock and run in lock-step two-phase cycles.

## Interface
Parameters:
- STACK_DEPTH, 2, return-stack entries (1..4)
- PROG_DEPTH, 16, program words; fixed, because the operand is 4 bits

Ports:
- CLK  in  1  system clock, shared with core
- RST_N  in  1  asynchronous active-low reset
- START  in  1  level; leave IDLE/HALT and run from PC=0
- PLD_WE  in  1  program-load write strobe, honoured only in IDLE/HALT
- PLD_ADDR  in  4  program-load address
- PLD_DATA  in  8  program word: [7:4] opcode, [3:0] operand address
- IO_IN  in  8  external inputs, data addresses 0-7
- IO_OUT  out  8  registered outputs, data addresses 8-15
- CPU_IR  out  4  to core IR_IN
- CPU_DIN  out  1  to core DATAIN
- CPU_RST  out  1  to core RST, active high
- CPU_FL0, CPU_JMP, CPU_RTN, CPU_FLF  in  1 each  core flags
- CPU_DOUT  in  1  core DATAOUT
- CPU_WRT  in  1  core WRT
- TICK  out  1  one-cycle pulse per FL0 instruction
- HALTED  out  1  high in HALT

Reset is decided as: one clock CLK; RST_N asynchronous, active-low.

## Operation
- States: IDLE (reset), RUN, HALT.
- IDLE/HALT: CPU_RST=1, CPU_IR=4'hF, PH held 0, program writes accepted (prog[PLD_ADDR] <= PLD_DATA on each edge with PLD_WE=1).
- START=1 in IDLE/HALT: next edge enters RUN with PC=0, SP=0, PH=0, CPU_RST=0. Stack is cleared, IO_OUT is kept.
- RUN: PH toggles every edge. PH=0 marks the fetch cycle; CPU_IR=prog[PC][7:4] combinationally, and ADDR <= prog[PC][3:0] on the PH=0 edge.
- CPU_DIN = data[ADDR], registered: 0-7 read IO_IN[ADDR], 8-15 read back IO_OUT[ADDR-8].
- CPU_WRT sampled 1: if ADDR>=8, IO_OUT[ADDR-8] <= CPU_DOUT on that edge. Writes to 0-7 are ignored.
- PC update on the PH=1 edge, priority order:
  - CPU_JMP: push PC+1, PC <= ADDR.
  - else CPU_RTN: PC <= pop.
  - else PC+1, wrapping 15->0.
- Stack full on JMP: oldest entry discarded (shift). Stack empty on RTN: PC <= 0.
- CPU_FLF sampled 1 on a PH=1 edge: enter HALT, HALTED=1, CPU_RST asserted next cycle. START held high restarts immediately.
- CPU_FL0 sampled 1 on a PH=1 edge: TICK=1 for the following cycle.
- Program load attempted during RUN is dropped silently.

## Timing
- Reset values: IO_OUT=0, CPU_IR=4'hF, CPU_DIN=0, CPU_RST=1, TICK=0, HALTED=0, PC=0, SP=0, PH=0, state IDLE. Program memory is not reset.
- Instruction rate: one instruction per 2 clocks. The core latches CPU_IR on the PH=0 edge.
- Jump latency: the target instruction is fetched in the PH=0 cycle immediately after the JMP's PH=1 edge; no bubble.
- RTN: the core skips the returned-to instruction by itself; the host does not suppress it.
- Async RST_N assertion mid-RUN: immediate return to IDLE and IO_OUT=0. Deassertion takes effect on the next CLK edge.
- CPU_WRT and CPU_JMP on the same edge are both honoured.

## Structure
- Shared package ue14500_pkg:
  - opcode localparams, 4'h0..4'hF, matching the core
  - state enum {IDLE, RUN, HALT}
  - IO address-split constant 8
- Sub-module ue14500_rstack: STACK_DEPTH entries, push/pop, full/empty, discard-oldest on overflow.

## Test plan
- Reset, then load prog[0]=8'hA0 (IEN, addr0), [1]=8'h10 (LD 0), [2]=8'hB0, [3]=8'h88 (STO 8), [4]=8'hF0; START with IO_IN[0]=1, OEN data path fed 1 -> IO_OUT[0]=1, HALTED=1 after 10 cycles.
- JMP: prog[2]=8'hC9 -> PC=9 on the next fetch. A later RTN returns PC=3.
- Three nested JMPs with STACK_DEPTH=2 -> first return address lost. Third RTN with empty stack -> PC=0.
- prog[5]=8'h00 -> TICK high exactly 1 cycle, 1 cycle after PC=5 executes.
- STO to address 3 -> IO_OUT unchanged. PLD_WE during RUN -> prog unchanged.
- RST_N pulled low mid-RUN with IO_OUT=8'hFF -> IO_OUT=0, CPU_RST=1, CPU_IR=4'hF within the same cycle.

Source files
------------

// File: rtl/ue14500_pkg.sv
// Shared definitions for the UE14500 host: core opcodes, host states and the I/O address map.
package ue14500_pkg;

    typedef enum logic [3:0] {
        OP_NOP0 = 4'h0, OP_LD   = 4'h1, OP_ADD  = 4'h2, OP_SUB  = 4'h3,
        OP_ONE  = 4'h4, OP_NAND = 4'h5, OP_OR   = 4'h6, OP_XOR  = 4'h7,
        OP_STO  = 4'h8, OP_STOC = 4'h9, OP_IEN  = 4'hA, OP_OEN  = 4'hB,
        OP_JMP  = 4'hC, OP_RTN  = 4'hD, OP_SKZ  = 4'hE, OP_NOPF = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    // Data addresses at or above this read back the output register.
    localparam logic [3:0] IO_SPLIT = 4'd8;

    function automatic logic data_bit(input logic [3:0] addr, input logic [7:0] ins,
                                      input logic [7:0] outs);
        return (addr >= IO_SPLIT) ? outs[addr[2:0]] : ins[addr[2:0]];
    endfunction

endpackage

// File: rtl/ue14500_rstack.sv
// Return-address stack; a push onto a full stack drops the oldest entry.
module ue14500_rstack
    import ue14500_pkg::*;
#(
    parameter int STACK_DEPTH = 2
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       clear,
    input  logic       push,
    input  logic       pop,
    input  logic [3:0] push_data,
    output logic [3:0] pop_data,
    output logic       empty
);

    localparam int CW = $clog2(STACK_DEPTH + 1);

    logic [3:0]    entries_q [STACK_DEPTH];
    logic [CW-1:0] count_q;
    logic          full;

    assign full  = (count_q == CW'(STACK_DEPTH));
    assign empty = (count_q == '0);

    always_comb begin
        pop_data = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (count_q == CW'(i + 1)) pop_data = entries_q[i];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_q <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) entries_q[i] <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (push) begin
            if (full) begin
                for (int i = 0; i < STACK_DEPTH - 1; i++) entries_q[i] <= entries_q[i+1];
                entries_q[STACK_DEPTH-1] <= push_data;
            end else begin
                for (int i = 0; i < STACK_DEPTH; i++) begin
                    if (count_q == CW'(i)) entries_q[i] <= push_data;
                end
                count_q <= count_q + CW'(1);
            end
        end else if (pop && !empty) begin
            count_q <= count_q - CW'(1);
        end
    end

endmodule

// File: rtl/ue14500_host.sv
// Host controller for the UE14500 core: program memory, PC, return stack and 16-bit I/O space.
module ue14500_host
    import ue14500_pkg::*;
#(
    parameter int STACK_DEPTH = 2,
    parameter int PROG_DEPTH  = 16
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       START,
    input  logic       PLD_WE,
    input  logic [3:0] PLD_ADDR,
    input  logic [7:0] PLD_DATA,
    input  logic [7:0] IO_IN,
    output logic [7:0] IO_OUT,
    output logic [3:0] CPU_IR,
    output logic       CPU_DIN,
    output logic       CPU_RST,
    input  logic       CPU_FL0,
    input  logic       CPU_JMP,
    input  logic       CPU_RTN,
    input  logic       CPU_FLF,
    input  logic       CPU_DOUT,
    input  logic       CPU_WRT,
    output logic       TICK,
    output logic       HALTED
);

    state_e     state_q;
    logic       ph_q;
    logic [3:0] pc_q;
    logic [3:0] addr_q;
    logic       din_q;
    logic       tick_q;
    logic [7:0] io_out_q;
    logic [7:0] prog_q [PROG_DEPTH];
    logic [7:0] cur_word;
    logic       run;
    logic       stk_push;
    logic       stk_pop;
    logic       stk_clear;
    logic [3:0] stk_pop_data;
    logic       stk_empty;

    assign run      = (state_q == RUN);
    assign cur_word = prog_q[pc_q];

    assign CPU_IR  = run ? cur_word[7:4] : OP_NOPF;
    assign CPU_DIN = din_q;
    assign CPU_RST = !run;
    assign IO_OUT  = io_out_q;
    assign TICK    = tick_q;
    assign HALTED  = (state_q == HALT);

    // JMP outranks RTN, so a simultaneous pop never happens.
    assign stk_push  = run && ph_q && CPU_JMP;
    assign stk_pop   = run && ph_q && !CPU_JMP && CPU_RTN;
    assign stk_clear = !run && START;

    ue14500_rstack #(
        .STACK_DEPTH(STACK_DEPTH)
    ) u_rstack (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .clear    (stk_clear),
        .push     (stk_push),
        .pop      (stk_pop),
        .push_data(pc_q + 4'd1),
        .pop_data (stk_pop_data),
        .empty    (stk_empty)
    );

    // Program memory is deliberately not reset.
    always_ff @(posedge CLK) begin
        if (PLD_WE && !run) prog_q[PLD_ADDR] <= PLD_DATA;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            ph_q     <= 1'b0;
            pc_q     <= 4'd0;
            addr_q   <= 4'd0;
            din_q    <= 1'b0;
            io_out_q <= 8'h00;
            tick_q   <= 1'b0;
        end else begin
            tick_q <= run && ph_q && CPU_FL0;
            if (!run) begin
                ph_q  <= 1'b0;
                din_q <= 1'b0;
                if (START) begin
                    state_q <= RUN;
                    pc_q    <= 4'd0;
                end
            end else begin
                ph_q <= !ph_q;
                if (CPU_WRT && addr_q >= IO_SPLIT) io_out_q[addr_q[2:0]] <= CPU_DOUT;
                if (!ph_q) begin
                    addr_q <= cur_word[3:0];
                    din_q  <= data_bit(cur_word[3:0], IO_IN, io_out_q);
                end else begin
                    if (CPU_JMP)      pc_q <= addr_q;
                    else if (CPU_RTN) pc_q <= stk_empty ? 4'd0 : stk_pop_data;
                    else              pc_q <= pc_q + 4'd1;
                    if (CPU_FLF) state_q <= HALT;
                end
            end
        end
    end

endmodule

// File: tb/tb_ue14500_host.sv
// Bench for ue14500_host: a small core emulator plus a behavioural host model, checked every cycle.
module tb_ue14500_host;

    localparam int STACK_DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       pld_we = 1'b0;
    logic [3:0] pld_addr = 4'd0;
    logic [7:0] pld_data = 8'd0;
    logic [7:0] io_in = 8'd0;
    logic [7:0] io_out;
    logic [3:0] cpu_ir;
    logic       cpu_din;
    logic       cpu_rst;
    logic       cpu_fl0 = 1'b0, cpu_jmp = 1'b0, cpu_rtn = 1'b0, cpu_flf = 1'b0;
    logic       cpu_dout = 1'b0, cpu_wrt = 1'b0;
    logic       tick;
    logic       halted;
    logic       jmp_wrt = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // Host model
    int         m_state = 0;  // 0 idle, 1 run, 2 halt
    logic       m_ph = 1'b0;
    logic [3:0] m_pc = 4'd0;
    logic [3:0] m_addr = 4'd0;
    logic       m_din = 1'b0;
    logic [7:0] m_io = 8'h00;
    logic       m_tick = 1'b0;
    logic [7:0] m_prog [16];
    logic [3:0] m_stack [$];
    // Core emulator
    logic [3:0] c_ir = 4'hF;
    logic       c_rr = 1'b0, c_ien = 1'b0, c_oen = 1'b0, c_skip = 1'b0;

    logic [7:0] img [16];

    always #5 clk = ~clk;

    ue14500_host #(
        .STACK_DEPTH(STACK_DEPTH),
        .PROG_DEPTH (16)
    ) dut (
        .CLK     (clk),
        .RST_N   (rst_n),
        .START   (start),
        .PLD_WE  (pld_we),
        .PLD_ADDR(pld_addr),
        .PLD_DATA(pld_data),
        .IO_IN   (io_in),
        .IO_OUT  (io_out),
        .CPU_IR  (cpu_ir),
        .CPU_DIN (cpu_din),
        .CPU_RST (cpu_rst),
        .CPU_FL0 (cpu_fl0),
        .CPU_JMP (cpu_jmp),
        .CPU_RTN (cpu_rtn),
        .CPU_FLF (cpu_flf),
        .CPU_DOUT(cpu_dout),
        .CPU_WRT (cpu_wrt),
        .TICK    (tick),
        .HALTED  (halted)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic core_clear();
        c_ir = 4'hF; c_rr = 1'b0; c_ien = 1'b0; c_oen = 1'b0; c_skip = 1'b0;
    endtask

    task automatic core_exec();
        if (c_skip) c_skip = 1'b0;
        else begin
            case (c_ir)
                4'h1: c_rr = m_din & c_ien;
                4'h4: c_rr = 1'b1;
                4'hA: c_ien = m_din;
                4'hB: c_oen = m_din;
                4'hD: c_skip = 1'b1;
                4'hE: if (!c_rr) c_skip = 1'b1;
                default: ;
            endcase
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_ph = 1'b0; m_pc = 4'd0; m_addr = 4'd0; m_din = 1'b0;
        m_io = 8'h00; m_tick = 1'b0;
        m_stack.delete();
        core_clear();
    endtask

    task automatic model_step();
        logic run;
        logic tick_n;
        run    = (m_state == 1);
        tick_n = run && m_ph && cpu_fl0;
        if (!run) begin
            if (pld_we) m_prog[pld_addr] = pld_data;
            m_ph = 1'b0; m_din = 1'b0;
            core_clear();
            if (start) begin
                m_state = 1; m_pc = 4'd0;
                m_stack.delete();
            end
        end else begin
            if (cpu_wrt && m_addr >= 4'd8) m_io[m_addr[2:0]] = cpu_dout;
            if (!m_ph) begin
                c_ir   = m_prog[m_pc][7:4];
                m_addr = m_prog[m_pc][3:0];
                m_din  = (m_addr >= 4'd8) ? m_io[m_addr[2:0]] : io_in[m_addr[2:0]];
            end else begin
                core_exec();
                if (cpu_jmp) begin
                    m_stack.push_back(m_pc + 4'd1);
                    if (m_stack.size() > STACK_DEPTH) m_stack.delete(0);
                    m_pc = m_addr;
                end else if (cpu_rtn) begin
                    m_pc = (m_stack.size() == 0) ? 4'd0 : m_stack.pop_back();
                end else begin
                    m_pc = m_pc + 4'd1;
                end
                if (cpu_flf) m_state = 2;
            end
            m_ph = !m_ph;
        end
        m_tick = tick_n;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // Compare against the model, then drive the core's outputs for the coming edge.
    always @(negedge clk) begin
        logic active;
        check("io_out",  io_out,       m_io);
        check("cpu_ir",  {4'h0, cpu_ir},  {4'h0, (m_state == 1) ? m_prog[m_pc][7:4] : 4'hF});
        check("cpu_din", {7'h0, cpu_din}, {7'h0, m_din});
        check("cpu_rst", {7'h0, cpu_rst}, {7'h0, (m_state != 1)});
        check("tick",    {7'h0, tick},    {7'h0, m_tick});
        check("halted",  {7'h0, halted},  {7'h0, (m_state == 2)});
        active   = (m_state == 1) && m_ph && !c_skip;
        cpu_fl0  = active && (c_ir == 4'h0);
        cpu_jmp  = active && (c_ir == 4'hC);
        cpu_rtn  = active && (c_ir == 4'hD);
        cpu_flf  = active && (c_ir == 4'hF);
        cpu_wrt  = active && ((c_oen && (c_ir == 4'h8 || c_ir == 4'h9)) ||
                              (jmp_wrt && c_ir == 4'hC));
        cpu_dout = (c_ir == 4'h8) ? c_rr : (c_ir == 4'h9) ? !c_rr : 1'b1;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic fill();
        for (int i = 0; i < 16; i++) img[i] = 8'hF0;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 16; i++) begin
            pld_we = 1'b1; pld_addr = 4'(i); pld_data = img[i];
            @(negedge clk);
        end
        pld_we = 1'b0;
    endtask

    task automatic start_run();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        cycles(2);
        check("rst_io_out", io_out, 8'h00);
        check("rst_ir", {4'h0, cpu_ir}, 8'h0F);
        check("rst_din", {7'h0, cpu_din}, 8'h00);
        check("rst_cpu_rst", {7'h0, cpu_rst}, 8'h01);
        check("rst_tick", {7'h0, tick}, 8'h00);
        check("rst_halted", {7'h0, halted}, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);

        // IEN, LD, OEN, STO 8, halt
        fill();
        img[0] = 8'hA0; img[1] = 8'h10; img[2] = 8'hB0; img[3] = 8'h88; img[4] = 8'hF0;
        load_prog();
        io_in = 8'h01;
        start_run();
        cycles(9);
        check("a_not_halted_yet", {7'h0, halted}, 8'h00);
        cycles(1);
        check("a_halted", {7'h0, halted}, 8'h01);
        check("a_io_out", io_out, 8'h01);
        check("a_cpu_rst", {7'h0, cpu_rst}, 8'h01);

        // JMP 9 with a write on the same edge, RTN to 3, STO 3, NOP0 tick, halt
        fill();
        img[0] = 8'hB0; img[1] = 8'h40; img[2] = 8'hC9; img[3] = 8'h60;
        img[4] = 8'h83; img[5] = 8'h00; img[6] = 8'hF0; img[9] = 8'hD0;
        load_prog();
        jmp_wrt = 1'b1;
        start_run();
        cycles(2);
        pld_we = 1'b1; pld_addr = 4'd6; pld_data = 8'h40;
        cycles(1);
        pld_we = 1'b0;
        cycles(3);
        check("b_jmp_target_ir", {4'h0, cpu_ir}, 8'h0D);
        check("b_jmp_wrt_io", io_out, 8'h03);
        cycles(2);
        check("b_rtn_ir", {4'h0, cpu_ir}, 8'h06);
        cycles(5);
        check("b_tick_before", {7'h0, tick}, 8'h00);
        cycles(1);
        check("b_tick_pulse", {7'h0, tick}, 8'h01);
        cycles(1);
        check("b_tick_after", {7'h0, tick}, 8'h00);
        check("b_not_halted_yet", {7'h0, halted}, 8'h00);
        cycles(1);
        check("b_halted", {7'h0, halted}, 8'h01);
        check("b_sto3_ignored", io_out, 8'h03);
        jmp_wrt = 1'b0;

        // Three nested JMPs overflow the two-entry stack
        fill();
        img[0] = 8'hC4; img[4] = 8'hC8; img[5] = 8'h60; img[6] = 8'hD0;
        img[8] = 8'hCC; img[9] = 8'h60; img[10] = 8'hD0; img[12] = 8'hD0;
        load_prog();
        start_run();
        cycles(8);
        check("c_rtn1_ir", {4'h0, cpu_ir}, 8'h06);
        cycles(4);
        check("c_rtn2_ir", {4'h0, cpu_ir}, 8'h06);
        cycles(4);
        check("c_rtn_empty_ir", {4'h0, cpu_ir}, 8'h0C);
        #2 rst_n = 1'b0;
        #1 check("c_reset_cpu_rst", {7'h0, cpu_rst}, 8'h01);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Fill IO_OUT with ones, then reset asynchronously mid-run
        fill();
        img[0] = 8'hB0; img[1] = 8'h40; img[10] = 8'hC0;
        for (int k = 0; k < 8; k++) img[2+k] = 8'(8'h88 + k);
        load_prog();
        io_in = 8'hFF;
        start_run();
        cycles(24);
        check("d_io_all_ones", io_out, 8'hFF);
        #2 rst_n = 1'b0;
        #1;
        check("d_async_io_out", io_out, 8'h00);
        check("d_async_cpu_rst", {7'h0, cpu_rst}, 8'h01);
        check("d_async_ir", {4'h0, cpu_ir}, 8'h0F);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
